ret_addr_stack: RTL

- Return-address stack that consumes the return address the branch unit emits on a call (branch_sig 3'b011, value pc+1).
- Returns that address on the matching return (branch_sig 3'b100) so the branch unit's des_addr input can be sourced from it.
- Sits between the branch unit and the PC/decode path.
- Circular LIFO with saturating occupancy count, sticky error flags, one-cycle registered pop data.

---
 rtl/ret_addr_stack_if.sv | 30 +++
 rtl/ret_addr_stack.sv | 99 +++++++++
 2 files changed

// File: rtl/ret_addr_stack_if.sv
// rtl/ret_addr_stack_if.sv - call/return port bundle between branch unit and return-address stack
interface ret_addr_stack_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int PTRW  = $clog2(DEPTH)
);
    logic          push;
    logic [AW-1:0] push_addr;
    logic          pop;
    logic          flush;
    logic          clr_err;
    logic [AW-1:0] top_addr;
    logic [AW-1:0] pop_addr;
    logic          pop_valid;
    logic [PTRW:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, push_addr, pop, flush, clr_err,
        input  top_addr, pop_addr, pop_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, push_addr, pop, flush, clr_err,
        output top_addr, pop_addr, pop_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - circular return-address LIFO with saturating count and sticky error flags
module ret_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    ret_addr_stack_if.slave       bus
);
    localparam logic [PTRW-1:0] TP_INIT = PTRW'(DEPTH - 1);
    localparam logic [PTRW:0]   CNT_MAX = (PTRW+1)'(DEPTH);

    logic [AW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] tp;
    logic [PTRW:0]   cnt;
    logic [AW-1:0]   pop_addr_q;
    logic            pop_valid_q;
    logic            overflow_q;
    logic            underflow_q;

    logic            is_empty;
    logic            is_full;
    logic            mem_we;
    logic [PTRW-1:0] mem_waddr;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_MAX);

    // Push+pop with data replaces the top in place; push+pop when empty bypasses storage.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = tp + 1'b1;
        if (!bus.flush && bus.push) begin
            if (!bus.pop) begin
                mem_we = 1'b1;
            end else if (!is_empty) begin
                mem_we    = 1'b1;
                mem_waddr = tp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= bus.push_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp          <= TP_INIT;
            cnt         <= '0;
            pop_addr_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            // Clear first so an error event in the same cycle re-sets the flag.
            if (bus.clr_err) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            if (bus.flush) begin
                cnt <= '0;
                tp  <= TP_INIT;
            end else if (bus.push && !bus.pop) begin
                tp <= tp + 1'b1;
                if (is_full) begin
                    overflow_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (!bus.push && bus.pop) begin
                if (!is_empty) begin
                    pop_addr_q  <= mem[tp];
                    pop_valid_q <= 1'b1;
                    tp          <= tp - 1'b1;
                    cnt         <= cnt - 1'b1;
                end else begin
                    underflow_q <= 1'b1;
                end
            end else if (bus.push && bus.pop) begin
                pop_addr_q  <= is_empty ? bus.push_addr : mem[tp];
                pop_valid_q <= 1'b1;
            end
        end
    end

    assign bus.top_addr  = is_empty ? '0 : mem[tp];
    assign bus.pop_addr  = pop_addr_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
